// File: rtl/sand_scheduler.sv
// Frame sequencer for the sand updater: sweeps the playfield bottom-up, one 16-pixel word at a time.
// Optional SAND_SCHED_ALTDIR_EN: alternate the column direction on every other frame.
module sand_scheduler #(
    parameter int WORDS_PER_ROW = 40,
    parameter int ROWS          = 480,
    parameter int ADDR_W        = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       upd_region,
    output logic [31:0]       upd_floor,
    output logic              upd_screenbegin,
    output logic              upd_screenend,
    output logic              upd_docalc,
    input  logic [31:0]       upd_new_region,
    input  logic [31:0]       upd_new_floor
);

    localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_ROW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_R, S_RD_F, S_CAP, S_WR_F, S_WR_R, S_NEXT, S_DONE
    } state_t;

    state_t            r_state;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic              r_first;
    logic              r_busy;
    logic              r_done;
    logic              r_req;
    logic              r_we;
    logic              r_docalc;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_region;
    logic [31:0]       r_floor;

    logic              w_rev;
    logic              w_row_end;
    logic              w_last;
    logic [COL_W-1:0]  w_col_first;
    logic [ROW_W-1:0]  w_nxt_row;
    logic [COL_W-1:0]  w_nxt_col;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [ADDR_W-1:0] w_addr_r;
    logic [ADDR_W-1:0] w_addr_f;

    function automatic logic [ADDR_W-1:0] calc_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        calc_addr = ADDR_W'(row) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(col);
    endfunction

`ifdef SAND_SCHED_ALTDIR_EN
    logic r_parity;

    // Frame parity: odd frames sweep each row right to left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_parity <= ~r_parity;
        end
    end

    assign w_rev = r_parity;
`else
    assign w_rev = 1'b0;
`endif

    // Next word position; the row==0 test happens before any decrement so the row never wraps.
    always_comb begin
        w_col_first = w_rev ? COL_LAST : {COL_W{1'b0}};
        w_row_end   = w_rev ? (r_col == {COL_W{1'b0}}) : (r_col == COL_LAST);
        w_last      = w_row_end && (r_row == {ROW_W{1'b0}});
        if (r_state == S_IDLE) begin
            w_nxt_row = ROW_W'(ROWS - 2);
            w_nxt_col = w_col_first;
        end else if (w_row_end) begin
            w_nxt_row = r_row - ROW_W'(1);
            w_nxt_col = w_col_first;
        end else begin
            w_nxt_row = r_row;
            w_nxt_col = w_rev ? (r_col - COL_W'(1)) : (r_col + COL_W'(1));
        end
        w_nxt_addr = calc_addr(w_nxt_row, w_nxt_col);
        w_addr_r   = calc_addr(r_row, r_col);
        w_addr_f   = w_addr_r + ADDR_W'(WORDS_PER_ROW);
    end

    // Sweep FSM; every bus output is registered and held while a request waits for its grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_row    <= {ROW_W{1'b0}};
            r_col    <= {COL_W{1'b0}};
            r_first  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_docalc <= 1'b0;
            r_addr   <= {ADDR_W{1'b0}};
            r_region <= 32'd0;
            r_floor  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row   <= w_nxt_row;
                        r_col   <= w_nxt_col;
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_addr  <= w_nxt_addr;
                        r_state <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (mem_gnt) begin
                        r_addr  <= w_addr_f;
                        r_first <= 1'b1;
                        r_state <= S_RD_F;
                    end
                end
                S_RD_F: begin
                    // Region data returns exactly once, in the first cycle here, granted or not.
                    r_first <= 1'b0;
                    if (r_first) begin
                        r_region <= mem_rdata;
                    end
                    if (mem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_floor  <= mem_rdata;
                    r_req    <= 1'b1;
                    r_we     <= 1'b1;
                    r_docalc <= 1'b1;
                    r_state  <= S_WR_F;
                end
                S_WR_F: begin
                    if (mem_gnt) begin
                        r_addr  <= w_addr_r;
                        r_state <= S_WR_R;
                    end
                end
                S_WR_R: begin
                    if (mem_gnt) begin
                        r_req    <= 1'b0;
                        r_we     <= 1'b0;
                        r_docalc <= 1'b0;
                        r_state  <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_col   <= {COL_W{1'b0}};
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_row   <= w_nxt_row;
                        r_col   <= w_nxt_col;
                        r_req   <= 1'b1;
                        r_addr  <= w_nxt_addr;
                        r_state <= S_RD_R;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write data follows the updater, whose inputs are frozen while a write waits for its grant.
    always_comb begin
        case (r_state)
            S_WR_F:  mem_wdata = upd_new_floor;
            S_WR_R:  mem_wdata = upd_new_region;
            default: mem_wdata = 32'd0;
        endcase
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign mem_req         = r_req;
    assign mem_we          = r_we;
    assign mem_addr        = r_addr;
    assign upd_region      = r_region;
    assign upd_floor       = r_floor;
    assign upd_docalc      = r_docalc;
    assign upd_screenbegin = (r_col == {COL_W{1'b0}});
    assign upd_screenend   = (r_col == COL_LAST);

endmodule

// File: tb/tb_sand_scheduler.sv
// Scoreboard bench for sand_scheduler on a 2-word x 3-row playfield with a behavioural RAM and updater.
module tb_sand_scheduler;

    localparam int W = 2;
    localparam int R = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, mem_req, mem_we;
    logic          mem_gnt = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;
    logic [31:0]   upd_region, upd_floor, upd_new_region, upd_new_floor;
    logic          upd_screenbegin, upd_screenend, upd_docalc;

    logic [31:0]   mem [16];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            fidx = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   rg;
        logic [31:0]   fl;
        logic          sb;
        logic          se;
    } tx_t;
    tx_t exp_q[$];

    // Per-word hand values, indexed by region address (row*2+col); floor address is index+2.
    localparam logic [31:0] EXP_REG [4] = '{32'h0000_00F0, 32'h0000_0003, 32'h0000_000C, 32'h0000_0001};
    localparam logic [31:0] EXP_FLR [4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0030, 32'h0000_0000};
    localparam logic [31:0] EXP_NF  [4] = '{32'h0000_00F0, 32'h0000_0003, 32'h0000_003C, 32'h0000_0001};
    localparam logic [31:0] EXP_NR  [4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [31:0] FINAL_MEM [6] = '{32'h0, 32'h0, 32'h0000_00F0, 32'h0000_0003, 32'h0000_003C, 32'h0000_0001};

    sand_scheduler #(.WORDS_PER_ROW(W), .ROWS(R), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .upd_region(upd_region),
        .upd_floor(upd_floor), .upd_screenbegin(upd_screenbegin), .upd_screenend(upd_screenend),
        .upd_docalc(upd_docalc), .upd_new_region(upd_new_region), .upd_new_floor(upd_new_floor)
    );

    always #5 clk = ~clk;

    // Toy updater: a grain falls into the floor word wherever the floor is empty.
    assign upd_new_floor  = upd_docalc ? (upd_floor | upd_region) : upd_floor;
    assign upd_new_region = upd_docalc ? (upd_region & upd_floor) : upd_region;

    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0] = 32'h0000_00F0; mem[1] = 32'h0000_0003; mem[2] = 32'h0000_000C;
        mem[3] = 32'h0000_0001; mem[4] = 32'h0000_0030; mem[5] = 32'h0000_0000;
    endtask

    function automatic bit is_rev(input int f);
`ifdef SAND_SCHED_ALTDIR_EN
        return (f % 2) == 1;
`else
        return (f < 0);
`endif
    endfunction

    task automatic push_frame(input bit rev, input int n_items);
        int cnt = 0;
        for (int w = 0; w < 4; w++) begin
            int row, col, idx;
            tx_t t;
            row = (w < 2) ? 1 : 0;
            col = rev ? (1 - (w % 2)) : (w % 2);
            idx = row * W + col;
            t.sb = (col == 0); t.se = (col == W - 1);
            t.rg = EXP_REG[idx]; t.fl = EXP_FLR[idx];
            for (int s = 0; s < 4; s++) begin
                t.we    = (s >= 2);
                t.addr  = AW'((s == 1 || s == 2) ? idx + W : idx);
                t.wdata = (s == 2) ? EXP_NF[idx] : (s == 3) ? EXP_NR[idx] : 32'd0;
                if (cnt < n_items) exp_q.push_back(t);
                cnt++;
            end
        end
    endtask

    // Monitor: pops the scoreboard on every granted access, mid-cycle.
    initial begin
        tx_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && mem_req && mem_gnt) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_access: got we=%0d addr=%0d expected none", mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_we", 32'(mem_we), 32'(e.we));
                    check("acc_addr", 32'(mem_addr), 32'(e.addr));
                    check("screenbegin", 32'(upd_screenbegin), 32'(e.sb));
                    check("screenend", 32'(upd_screenend), 32'(e.se));
                    check("docalc", 32'(upd_docalc), 32'(e.we));
                    if (e.we) begin
                        check("acc_wdata", mem_wdata, e.wdata);
                        check("upd_region", upd_region, e.rg);
                        check("upd_floor", upd_floor, e.fl);
                    end
                end
            end
        end
    end

    task automatic run_frame(input string tag, input int stall_len, input int restart_k, input int exp_cycles);
        int busy_n = 0;
        int done_n = 0;
        int done_k = 0;
        int stall_left = stall_len;
        init_mem();
        push_frame(is_rev(fidx), 16);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            start = (k == restart_k);
            if (stall_left > 0 && mem_req && mem_we) begin
                mem_gnt = 1'b0;
                stall_left--;
                check({tag, "_stall_addr"}, 32'(mem_addr), 32'd4);
                check({tag, "_stall_we"}, 32'(mem_we), 32'd1);
                check({tag, "_stall_wdata"}, mem_wdata, 32'h0000_003C);
            end else begin
                mem_gnt = 1'b1;
            end
            #1;
            if (busy) busy_n++;
            if (done) begin done_n++; done_k = k; end
        end
        start = 1'b0; mem_gnt = 1'b1;
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_cycles - 1));
        check({tag, "_done_count"}, 32'(done_n), 32'd1);
        check({tag, "_start_to_done"}, 32'(done_k), 32'(exp_cycles));
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 6; i++) check({tag, "_final_mem"}, mem[i], FINAL_MEM[i]);
        fidx++;
    endtask

    initial begin
        bit found;
        init_mem();
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_region", upd_region, 32'd0);
        check("rst_floor", upd_floor, 32'd0);
        check("rst_docalc", 32'(upd_docalc), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame("frame_a", 0, 0, 25);
        run_frame("frame_restart", 0, 10, 25);
        run_frame("frame_stall", 3, 0, 28);
        run_frame("frame_again", 0, 0, 25);

        // Reset while the region write is pending.
        init_mem();
        push_frame(is_rev(fidx), 3);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            if (k > 1) @(negedge clk);
            if (mem_req && mem_we && mem_addr == 4'd2) found = 1'b1;
        end
        check("rst_mid_found_wr_r", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("rst_mid_no_write", mem[2], 32'h0000_000C);
        check("rst_mid_floor_kept", mem[4], 32'h0000_003C);
        @(negedge clk); reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            check("rst_mid_done", 32'(done), 32'd0);
        end
        check("rst_mid_queue", 32'(exp_q.size()), 32'd0);
        fidx = 0;

        run_frame("frame_post_reset", 0, 0, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sand_scheduler.md
Name: sand_scheduler

Overview:
- Frame-level sequencer for the combinational sand-physics word updater.
- Once per frame, sweeps the 2-bit-per-pixel playfield RAM bottom-up. For each 16-pixel word it reads the region word (row r) and the floor word (row r+1), drives the updater, and writes both results back.
- Shares the single RAM port with the VGA scan-out path through a req/gnt handshake. Sits between the frame-start pulse, the RAM arbiter and the updater.

Parameters:
- WORDS_PER_ROW, 40, 32-bit words per row (16 pixels each).
- ROWS, 480, rows in playfield.
- ADDR_W, 15, RAM word-address width; must satisfy 2^ADDR_W >= ROWS*WORDS_PER_ROW.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame-update request (vsync-derived)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when sweep completes
- mem_req  out  1  RAM access request
- mem_gnt  in  1  RAM access granted this cycle
- mem_we  out  1  1 = write, 0 = read (qualified by mem_req)
- mem_addr  out  ADDR_W  word address = row*WORDS_PER_ROW + col
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after a granted read
- upd_region  out  32  latched region word to updater
- upd_floor  out  32  latched floor word to updater
- upd_screenbegin  out  1  col == 0 (leftmost word of row)
- upd_screenend  out  1  col == WORDS_PER_ROW-1
- upd_docalc  out  1  high in S_WR_F and S_WR_R
- upd_new_region  in  32  updater result, region
- upd_new_floor  in  32  updater result, floor

Behaviour:
- Reset (async, reset_n low): state = S_IDLE.
  - busy, done, mem_req, mem_we, upd_docalc = 0.
  - mem_addr, mem_wdata, upd_region, upd_floor = 0; row/col counters = 0.
- States: S_IDLE, S_RD_R, S_RD_F, S_CAP, S_WR_F, S_WR_R, S_NEXT, S_DONE.
- S_IDLE:
  - On start: row = ROWS-2, col = 0, busy = 1, go to S_RD_R.
  - start while busy is ignored (not queued).
- S_RD_R: mem_req=1, we=0, addr = row*W+col. Advance on mem_gnt.
- S_RD_F: mem_req=1, we=0, addr = (row+1)*W+col. Advance on mem_gnt.
  - Region data arrives in the first cycle of S_RD_F (the cycle after the S_RD_R grant) and is latched into upd_region then, whether or not this state's own read is granted.
- S_CAP: mem_req=0. Latch mem_rdata into upd_floor. Advance unconditionally.
- S_WR_F: mem_req=1, we=1, addr = floor address, wdata = upd_new_floor. Advance on mem_gnt.
- S_WR_R: mem_req=1, we=1, addr = region address, wdata = upd_new_region. Advance on mem_gnt.
- S_NEXT: mem_req=0.
  - If col < W-1: col++.
  - Else col = 0 and row--; if row was 0, go to S_DONE.
  - Otherwise go to S_RD_R.
- S_DONE: done = 1 for one cycle, busy = 0, go to S_IDLE.
- Stall rules:
  - Without mem_gnt, the state holds and mem_addr, mem_we and mem_wdata stay stable.
  - mem_req stays asserted until granted; it is never withdrawn mid-request.
- Cycle timing:
  - Latency with gnt tied high: 6 cycles per word (RD_R, RD_F, CAP, WR_F, WR_R, NEXT).
  - Frame = ROWS-1 rows * W words * 6 cycles, +1 cycle for S_DONE.
- Arithmetic and sweep rules:
  - Address arithmetic is unsigned, truncated to ADDR_W.
  - The row counter never underflows: the row==0 check precedes the decrement.
  - Row ROWS-1 is never a region (floor only); row 0 is never a floor.
- Write order and word range:
  - Floor is written before region, so a falling grain is never duplicated.
  - Per-row words run left to right, col 0..W-1.
- upd_screenbegin and upd_screenend are decoded from the col counter and are stable from S_RD_R through S_WR_R.
- Reset mid-sweep aborts immediately: no pending write completes, done is not pulsed.

Optional Feature:
- SAND_SCHED_ALTDIR_EN
- Defined:
  - A 1-bit frame parity flop toggles at each S_DONE; reset value 0.
  - On odd frames col runs W-1 down to 0 and ends the row at 0.
  - screenbegin and screenend stay tied to physical col 0 and W-1 in both directions.
- Undefined: always left to right; no parity flop.

Test Plan:
- Geometry: all scenarios use W=2, ROWS=3, gnt tied 1, start pulse.
  - Expected access order: reads then writes at addrs 2/4, 3/5, 0/2, 1/3.
  - busy for 24 cycles, done pulses once; 25 cycles start-to-done.
- Region word 0x00000001 at row 1 col 1, floor 0 at row 2 col 1:
  - Updater outputs are written back: addr 5 gets new_floor, then addr 3 gets new_region.
  - upd_screenend=1 and upd_screenbegin=0 during that word.
- mem_gnt held 0 for 3 cycles during S_WR_F:
  - mem_addr, we and wdata are unchanged across the stall.
  - Frame completes 3 cycles later (28 total).
- start re-pulsed at cycle 10 of a sweep:
  - Ignored; exactly one done.
  - A start issued after done launches a new sweep.
- reset_n asserted during S_WR_R:
  - Next cycle mem_req=0, busy=0, no write occurs; done stays 0.
- SAND_SCHED_ALTDIR_EN defined, two back-to-back frames:
  - Frame 2 visits cols in order 1, 0 per row.
  - screenend=1 on the col-1 word in both frames.
